// File: rtl/kyber_pkg.sv
// Shared constants and types for the Kyber toy-ring (N=8) NTT-domain datapath.
// Holds Q, widths, the per-pair ZETA table, the Barrett constants and a modular add helper.
// No ports; imported by barrett_reduce and pointwise_basemul.
package kyber_pkg;
  localparam int Q   = 3329;
  localparam int W   = 12;
  localparam int N   = 8;
  localparam int NP  = N / 2;
  localparam int SW  = W + 1;

  // Barrett: q_est = (x * M) >> SHIFT with M = floor(2^26 / Q).
  // For x < 2^25 the estimate is short by at most one Q, so a single
  // conditional subtract yields the canonical residue.
  localparam int BARRETT_M     = 20158;
  localparam int BARRETT_SHIFT = 26;
  localparam int RED_W         = 25;

  typedef logic [W-1:0] coeff_t;
  typedef logic [NP-1:0][W-1:0] zeta_tab_t;

  // Pair i is reduced mod (X^2 - ZETA[i]); the four entries are the primitive
  // 8th roots of unity mod Q (17^32, -17^32, 17^96, -17^96). Index 0 is rightmost.
  localparam zeta_tab_t ZETA = {12'd40, 12'd3289, 12'd749, 12'd2580};

  // (x + y) mod Q for canonical x, y.
  function automatic coeff_t mod_add(input coeff_t x, input coeff_t y);
    logic [SW-1:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= SW'(Q)) s = s - SW'(Q);
    return s[W-1:0];
  endfunction
endpackage

// File: rtl/barrett_reduce.sv
// Combinational Barrett reduction: y = x mod Q, canonical [0, Q-1].
// Ports: x [RED_W-1:0] in (any value < 2^25), y coeff_t out.
// Latency 0; purely combinational, no flow control.
module barrett_reduce
  import kyber_pkg::*;
(
  input  logic [RED_W-1:0] x,
  output coeff_t           y
);
  logic [13:0] q_est;
  logic [12:0] rem;

  assign q_est = 14'(({15'd0, x} * 40'(BARRETT_M)) >> BARRETT_SHIFT);
  // Remainder lies in [0, 2Q), so 13 bits are enough after the subtract.
  assign rem   = 13'({1'b0, x} - 26'(q_est) * 26'(Q));
  assign y     = (rem >= 13'(Q)) ? W'(rem - 13'(Q)) : rem[W-1:0];
endmodule

// File: rtl/pointwise_basemul.sv
// Pipelined NTT-domain pointwise multiplier, c = a o b over 4 degree-1 pairs mod (X^2 - ZETA[i]).
// Ports: clk, r (sync active-low reset), valid_in, a_coeffs/b_coeffs [N][W] in; valid_out, coeffs_out [N][W] out.
// Latency 4 (5 with BASEMUL_ACC_EN, which adds acc_first/acc_last inputs and an accumulate stage); no backpressure.
module pointwise_basemul
  import kyber_pkg::*;
(
  input  logic                clk,
  input  logic                r,
  input  logic                valid_in,
  input  logic [N-1:0][W-1:0] a_coeffs,
  input  logic [N-1:0][W-1:0] b_coeffs,
`ifdef BASEMUL_ACC_EN
  input  logic                acc_first,
  input  logic                acc_last,
`endif
  output logic                valid_out,
  output logic [N-1:0][W-1:0] coeffs_out
);
  logic v1, v2, v3, v4;
  logic [N-1:0][W-1:0] c4;

  // Valid bits advance every cycle regardless of data.
  always_ff @(posedge clk) begin
    if (!r) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
    end else begin
      v1 <= valid_in; v2 <= v1; v3 <= v2; v4 <= v3;
    end
  end

  for (genvar i = 0; i < NP; i++) begin : g_pair
    logic [23:0] p00_1, p11_1, p01_1, p10_1;
    logic [23:0] p00_2;
    coeff_t      t_2;
    logic [24:0] s_2;
    logic [23:0] p00_3, u_3;
    coeff_t      c1_3;
    coeff_t      c0_4, c1_4;
    coeff_t      t_red, c1_red, c0_red;

    always_ff @(posedge clk) begin
      if (!r) begin
        p00_1 <= '0; p11_1 <= '0; p01_1 <= '0; p10_1 <= '0;
        p00_2 <= '0; t_2 <= '0; s_2 <= '0;
        p00_3 <= '0; u_3 <= '0; c1_3 <= '0;
        c0_4 <= '0; c1_4 <= '0;
      end else begin
        if (valid_in) begin
          p00_1 <= 24'(a_coeffs[2*i])   * 24'(b_coeffs[2*i]);
          p11_1 <= 24'(a_coeffs[2*i+1]) * 24'(b_coeffs[2*i+1]);
          p01_1 <= 24'(a_coeffs[2*i])   * 24'(b_coeffs[2*i+1]);
          p10_1 <= 24'(a_coeffs[2*i+1]) * 24'(b_coeffs[2*i]);
        end
        if (v1) begin
          p00_2 <= p00_1;
          t_2   <= t_red;
          s_2   <= 25'(p01_1) + 25'(p10_1);
        end
        if (v2) begin
          p00_3 <= p00_2;
          u_3   <= 24'(t_2) * 24'(ZETA[i]);
          c1_3  <= c1_red;
        end
        if (v3) begin
          c0_4 <= c0_red;
          c1_4 <= c1_3;
        end
      end
    end

    barrett_reduce u_red_t  (.x({1'b0, p11_1}),             .y(t_red));
    barrett_reduce u_red_s  (.x(s_2),                       .y(c1_red));
    barrett_reduce u_red_c0 (.x(25'(p00_3) + 25'(u_3)),     .y(c0_red));

    assign c4[2*i]   = c0_4;
    assign c4[2*i+1] = c1_4;
  end

`ifdef BASEMUL_ACC_EN
  logic f1, f2, f3, f4, l1, l2, l3, l4;
  logic                vo_q;
  logic [N-1:0][W-1:0] acc, acc_nxt, out_q;

  always_ff @(posedge clk) begin
    if (!r) begin
      f1 <= 1'b0; f2 <= 1'b0; f3 <= 1'b0; f4 <= 1'b0;
      l1 <= 1'b0; l2 <= 1'b0; l3 <= 1'b0; l4 <= 1'b0;
    end else begin
      f1 <= acc_first; f2 <= f1; f3 <= f2; f4 <= f3;
      l1 <= acc_last;  l2 <= l1; l3 <= l2; l4 <= l3;
    end
  end

  // A first-tagged vector restarts the sum; anything else folds into it.
  always_comb begin
    acc_nxt = '0;
    for (int k = 0; k < N; k++)
      acc_nxt[k] = f4 ? c4[k] : mod_add(acc[k], c4[k]);
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      acc   <= '0;
      out_q <= '0;
      vo_q  <= 1'b0;
    end else begin
      vo_q <= v4 & l4;
      if (v4) begin
        acc <= acc_nxt;
        if (l4) out_q <= acc_nxt;
      end
    end
  end

  assign valid_out  = vo_q;
  assign coeffs_out = out_q;
`else
  assign valid_out  = v4;
  assign coeffs_out = c4;
`endif
endmodule

// File: tb/tb_pointwise_basemul.sv
module tb_pointwise_basemul;
  localparam int Q = 3329;
`ifdef BASEMUL_ACC_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  typedef logic [7:0][11:0] vec_t;
  typedef struct {
    vec_t c;
    int   issue;
  } exp_t;

  logic clk, r, valid_in, valid_out;
  vec_t a_coeffs, b_coeffs, coeffs_out;
`ifdef BASEMUL_ACC_EN
  logic acc_first, acc_last;
`endif

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  pointwise_basemul dut (
    .clk(clk), .r(r), .valid_in(valid_in),
    .a_coeffs(a_coeffs), .b_coeffs(b_coeffs),
`ifdef BASEMUL_ACC_EN
    .acc_first(acc_first), .acc_last(acc_last),
`endif
    .valid_out(valid_out), .coeffs_out(coeffs_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int zeta(input int i);
    case (i)
      0: return 2580;
      1: return 749;
      2: return 3289;
      default: return 40;
    endcase
  endfunction

  // Golden model: schoolbook product mod (X^2 - zeta) using plain integer %.
  function automatic vec_t model(input vec_t a, input vec_t b);
    vec_t c;
    int a0, a1, b0, b1;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      a0 = int'(a[2*i]); a1 = int'(a[2*i+1]);
      b0 = int'(b[2*i]); b1 = int'(b[2*i+1]);
      c[2*i]   = 12'((a0*b0 + ((a1*b1) % Q) * zeta(i)) % Q);
      c[2*i+1] = 12'((a0*b1 + a1*b0) % Q);
    end
    return c;
  endfunction

  task automatic chk_vec(input string nm, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic send(input vec_t a, input vec_t b, input bit push, input vec_t exp,
                      input bit first, input bit last);
    exp_t e;
    @(negedge clk);
    a_coeffs = a;
    b_coeffs = b;
    valid_in = 1'b1;
`ifdef BASEMUL_ACC_EN
    acc_first = first;
    acc_last  = last;
`else
    if (first != last) begin end
`endif
    if (push) begin
      e.c = exp;
      e.issue = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a vector.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid_out: got %h want no output", coeffs_out);
        end else begin
          e = sb.pop_front();
          chk_vec("coeffs", coeffs_out, e.c);
          chk_int("latency", cyc + 1 - e.issue, LAT);
        end
      end
    end
  end

  initial begin
    vec_t a, b, e;
    r = 1'b0;
    valid_in = 1'b0;
    a_coeffs = '0;
    b_coeffs = '0;
`ifdef BASEMUL_ACC_EN
    acc_first = 1'b1;
    acc_last  = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk_int("reset_valid_out", int'(valid_out), 0);
    chk_vec("reset_coeffs_out", coeffs_out, '0);
    r = 1'b1;

    // 1: b = [1,0,...] is the identity, c = a
    for (int i = 0; i < 8; i++) begin
      a[i] = 12'(i + 1);
      b[i] = (i % 2 == 0) ? 12'd1 : 12'd0;
    end
    send(a, b, 1, a, 1, 1);
    idle(1);

    // 2: X * X = zeta in each pair
    for (int i = 0; i < 8; i++) begin
      a[i] = (i % 2 == 0) ? 12'd0 : 12'd1;
      e[i] = (i % 2 == 0) ? 12'(zeta(i / 2)) : 12'd0;
    end
    send(a, a, 1, e, 1, 1);
    idle(1);

    // 3: (-1 - X)^2 = 1 + zeta + 2X
    a = {8{12'd3328}};
    e = {12'd2, 12'd41, 12'd2, 12'd3290, 12'd2, 12'd750, 12'd2, 12'd2581};
    send(a, a, 1, e, 1, 1);
    // largest legal input, hand values 852*(1+zeta) and 1704
    a = {8{12'd4095}};
    e = {12'd1704, 12'd1642, 12'd1704, 12'd62, 12'd1704, 12'd3161, 12'd1704, 12'd1872};
    send(a, a, 1, e, 1, 1);
    idle(2);

    // 4: three back-to-back vectors
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        a[i] = 12'(100 * k + 37 * i + 5);
        b[i] = 12'(4000 - 211 * k - 13 * i);
      end
      send(a, b, 1, model(a, b), 1, 1);
    end
    idle(8);

    // 5: reset two edges after issue drops the vector
    a = {8{12'd77}};
    send(a, a, 0, '0, 1, 1);
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    r = 1'b0;
    @(negedge clk);
    chk_int("midreset_valid_out", int'(valid_out), 0);
    chk_vec("midreset_coeffs_out", coeffs_out, '0);
    r = 1'b1;
    idle(7);
    for (int i = 0; i < 8; i++) begin
      a[i] = 12'(3000 + i);
      b[i] = 12'(11 * i + 1);
    end
    send(a, b, 1, model(a, b), 1, 1);
    idle(6);

`ifdef BASEMUL_ACC_EN
    // 6: accumulate three identical unit vectors
    a = '0;
    a[0] = 12'd1;
    e = '0;
    e[0] = 12'd3;
    send(a, a, 0, '0, 1, 0);
    send(a, a, 0, '0, 0, 0);
    send(a, a, 1, e, 0, 1);
    idle(8);
`endif

    // random vectors against the model, back-to-back
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 8; i++) begin
        a[i] = 12'($urandom_range(0, 4095));
        b[i] = 12'($urandom_range(0, 4095));
      end
      send(a, b, 1, model(a, b), 1, 1);
    end
    idle(1);

    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    chk_int("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
